// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// fetch-side and data-side request ports of the core.
//   * One grant per cycle, memory port driven combinationally from the winner.
//   * Read data returns one cycle after the grant and is routed to its owner.
//   * Default policy: data priority, with a starvation guard that forces a
//     pending fetch through after STARVE_LIMIT consecutive losses.
//   * Optional macro ARB_ROUND_ROBIN_EN: replaces the starvation guard with
//     a one-bit last-grant register; on conflict the port not granted last
//     wins (data wins the first conflict after reset).
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  // fetch-side request port
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // data-side request port
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // shared memory port
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  // Owner of the response arriving in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  owner_e r_owner;
  owner_e w_owner_next;
  logic   r_resp_load;
  logic   w_inst_wins;
  logic   w_inst_grant;
  logic   w_data_grant;

`ifdef ARB_ROUND_ROBIN_EN

  // 1 = data was granted most recently, 0 = fetch (reset value).
  logic r_last_grant_data;

  // On conflict the side not granted last goes first.
  always_comb begin
    w_inst_wins = r_last_grant_data;
  end

  // Remember which side took the most recent grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last_grant_data <= 1'b0;
    end else if (w_inst_grant) begin
      r_last_grant_data <= 1'b0;
    end else if (w_data_grant) begin
      r_last_grant_data <= 1'b1;
    end
  end

`else

  // Width holds 0..STARVE_LIMIT; never narrower than one bit.
  localparam int unsigned CNT_W =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] r_starve_cnt;

  // Fetch overrides data priority once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    w_inst_wins = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  end

  // Count consecutive cycles a pending fetch loses; saturate at the limit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (!inst_req || w_inst_grant) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

`endif

  // Grant selection: single requester always wins, conflicts use the policy.
  always_comb begin
    w_inst_grant = 1'b0;
    w_data_grant = 1'b0;
    if (resetn) begin
      if (inst_req && data_req) begin
        w_inst_grant = w_inst_wins;
        w_data_grant = ~w_inst_wins;
      end else begin
        w_inst_grant = inst_req;
        w_data_grant = data_req;
      end
    end
  end

  // Acceptance strobes are the grants themselves.
  always_comb begin
    inst_addr_ok = w_inst_grant;
    data_addr_ok = w_data_grant;
  end

  // Drive the shared memory port from the granted requester; idle is all-zero.
  always_comb begin
    mem_en    = w_inst_grant | w_data_grant;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_data_grant) begin
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      if (data_wr) begin
        mem_we = data_wstrb;
      end
    end else if (w_inst_grant) begin
      mem_addr = inst_addr;
    end
  end

  // Response owner state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // Next response owner follows this cycle's grant; no grant means no response.
  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_inst_grant) begin
      w_owner_next = OWN_INST;
    end else if (w_data_grant) begin
      w_owner_next = OWN_DATA;
    end
  end

  // Remember whether the in-flight data access is a load (stores return no data).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_resp_load <= 1'b0;
    end else begin
      r_resp_load <= w_data_grant & ~data_wr;
    end
  end

  // Route the returning read data; a response in flight is dropped while in reset.
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    if (resetn) begin
      case (r_owner)
        OWN_INST: begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_rdata;
        end
        OWN_DATA: begin
          data_data_ok = 1'b1;
          if (r_resp_load) begin
            data_rdata = mem_rdata;
          end
        end
        default: begin
          inst_data_ok = 1'b0;
          data_data_ok = 1'b0;
        end
      endcase
    end
  end

  // Byte-strobe width is fixed by DATA_W; keep the relation explicit.
  if (STRB_W * 8 != DATA_W) begin : g_width_check
    $error("DATA_W must be a multiple of 8");
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed steps followed by a
// randomized phase, every cycle compared against a behavioural model of the
// arbitration and response-routing rules.
module tb_sram_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW / 8;
  localparam int          LIMIT = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_en;
  logic [SW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: who owns next cycle's response, and arbitration history.
  int pend      = 0;   // 0 none, 1 fetch, 2 data
  bit pend_load = 1'b0;
  int losses    = 0;   // consecutive cycles a fetch request lost
  bit last_data = 1'b0; // last grant went to data

  // Grant observed on the DUT in the most recent cycle.
  logic obs_dg;
  logic obs_ig;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rn, input bit ir, input logic [AW-1:0] ia,
                       input bit dr, input bit dw, input logic [SW-1:0] ds,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input logic [DW-1:0] mr);
    resetn     = rn;
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wr    = dw;
    data_wstrb = ds;
    data_addr  = da;
    data_wdata = dd;
    mem_rdata  = mr;
  endtask

  // One clock cycle: check at mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit ig, dg, inst_first, iok, dok;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [SW-1:0] e_we;
    #4;
    ig = 1'b0;
    dg = 1'b0;
    if (resetn) begin
`ifdef ARB_ROUND_ROBIN_EN
      inst_first = last_data;
`else
      inst_first = (losses >= LIMIT);
`endif
      if (inst_req && data_req) begin
        ig = inst_first;
        dg = !inst_first;
      end else begin
        ig = inst_req;
        dg = data_req;
      end
    end
    e_addr  = dg ? data_addr : (ig ? inst_addr : '0);
    e_wdata = dg ? data_wdata : '0;
    e_we    = (dg && data_wr) ? data_wstrb : '0;
    iok = resetn && (pend == 1);
    dok = resetn && (pend == 2);

    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(ig));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(dg));
    chk("mem_en", 64'(mem_en), 64'(ig | dg));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("inst_data_ok", 64'(inst_data_ok), 64'(iok));
    chk("inst_rdata", 64'(inst_rdata), iok ? 64'(mem_rdata) : 64'(0));
    chk("data_data_ok", 64'(data_data_ok), 64'(dok));
    chk("data_rdata", 64'(data_rdata), (dok && pend_load) ? 64'(mem_rdata) : 64'(0));
    obs_ig = inst_addr_ok;
    obs_dg = data_addr_ok;

    @(posedge clk);
    if (!resetn) begin
      pend      = 0;
      pend_load = 1'b0;
      losses    = 0;
      last_data = 1'b0;
    end else begin
      pend      = ig ? 1 : (dg ? 2 : 0);
      pend_load = dg && !data_wr;
      if (ig) last_data = 1'b0;
      if (dg) last_data = 1'b1;
      if (inst_req && !ig) losses = (losses < LIMIT) ? losses + 1 : losses;
      else                 losses = 0;
    end
    #1;
  endtask

  task automatic idle(input logic [DW-1:0] mr);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, mr);
    tick();
  endtask

  initial begin
    bit exp_d;
    drive(1'b0, 1'b1, 32'h1c00_0000, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 32'h0);
    #1;

    // Reset held with both requesting: nothing accepted, memory idle.
    for (int i = 0; i < 3; i++) tick();

    // First cycle after release: data wins the conflict.
    drive(1'b1, 1'b1, 32'h1c00_0000, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 32'h0);
    tick();
    chk("release_data_first", 64'(obs_dg), 64'(1));
    idle(32'hdead_beef);

    // Single fetch stream with read data returned one cycle later.
    drive(1'b1, 1'b1, 32'h1c00_0000, 1'b0, 1'b0, '0, '0, '0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h1c00_0004, 1'b0, 1'b0, '0, '0, '0, 32'h11);
    tick();
    drive(1'b1, 1'b1, 32'h1c00_0008, 1'b0, 1'b0, '0, '0, '0, 32'h22);
    tick();
    idle(32'h33);
    chk("fetch3_rdata", 64'(inst_rdata), 64'(0));

    // Store then load of the same word; store response carries no data.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD, 32'h0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0, 32'h5a5a_5a5a);
    tick();
    idle(32'h0000_CCDD);
    // Store with all strobes off still gets a grant and a response.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'b0000, 32'h104, 32'h1234_5678, 32'h0);
    tick();
    idle(32'h7777_7777);

    // Sustained conflict from a fresh reset.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 32'h0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 32'h1c00_0000 + 32'(i * 4), 1'b1, 1'b0, 4'h0,
            32'h300 + 32'(i * 4), 32'h0, $urandom);
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = !(i == 4 || i == 9);
`endif
      chk("conflict_pattern", 64'(obs_dg), 64'(exp_d));
    end
    idle($urandom);

    // Reset arriving while a load response is in flight drops it.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 32'h9999_9999);
    tick();
    chk("midflight_no_ok", 64'(data_data_ok), 64'(0));
    idle(32'h8888_8888);
    chk("post_reset_no_ok", 64'(data_data_ok), 64'(0));
    idle(32'h8888_8888);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'h1c00_1000, 1'b1, 1'b1, 4'hf, 32'h500, $urandom, $urandom);
      tick();
    end
    idle($urandom);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 40) != 0, ($urandom % 4) != 0, $urandom,
            ($urandom % 2) != 0, ($urandom % 2) != 0, 4'($urandom),
            $urandom, $urandom, $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the fetch-side and the data-side SRAM-like request ports of the pipelined CPU core.
- Accepts at most one request per cycle and drives the shared memory port.
- Routes the 1-cycle-latency response back to the port that owns it.
- Default policy: data side has priority, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width of both request ports and the memory port.
- DATA_W, 32, data width; byte-strobe width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive cycles a pending fetch request may lose arbitration before it is forced to win.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  synchronous active-low reset.
- inst_req  in  1  fetch request valid.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch read data valid.
- inst_rdata  out  DATA_W  fetch read data.
- data_req  in  1  data request valid.
- data_wr  in  1  1 = store, 0 = load.
- data_wstrb  in  DATA_W/8  store byte enables.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data response; for loads, data_rdata is valid.
- data_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access enable.
- mem_we  out  DATA_W/8  memory byte write enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en.

Behaviour:
- Request acceptance:
  - A request is accepted when req=1 and addr_ok=1 in the same cycle.
  - addr_ok is combinational from req, the arbitration state and resetn.
  - At most one of inst_addr_ok/data_addr_ok is high per cycle.
  - Both are 0 while resetn=0.
- Memory port (combinational):
  - mem_en = inst_addr_ok | data_addr_ok.
  - mem_addr/mem_wdata are muxed from the granted port.
  - mem_we = data_wstrb when a data store is granted, else 0.
  - A data_wr=1 request with data_wstrb=0 is still granted and still gets data_data_ok.
  - When nothing is granted: mem_addr = 0, mem_wdata = 0.
- Response tracking (state resp_owner: NONE, INST, DATA):
  - Next state = INST if inst granted, DATA if data granted, else NONE.
  - Back-to-back grants every cycle are allowed (full throughput, no bubble).
- Responses, registered/aligned to the cycle after the grant:
  - inst_data_ok = (resp_owner==INST); inst_rdata = mem_rdata when inst_data_ok, else 0.
  - data_data_ok = (resp_owner==DATA); data_rdata = mem_rdata for loads, 0 for stores and when data_data_ok=0.
  - data_ok cannot be back-pressured; requesters must sample it.
- Arbitration (default):
  - Only data_req: data wins. Only inst_req: inst wins.
  - Both requesting: data wins unless starve_cnt == STARVE_LIMIT, then inst wins.
- Starvation counter (starve_cnt, width clog2(STARVE_LIMIT+1)):
  - Increments each cycle inst_req=1 and inst is not granted; saturates at STARVE_LIMIT.
  - Clears to 0 when inst is granted or inst_req=0.
- Reset values (resetn=0 at an edge):
  - resp_owner=NONE, starve_cnt=0.
  - In the following cycle: all *_data_ok=0, all rdata=0, mem_en=0, mem_we=0.
- Reset mid-operation: a response in flight is dropped; no data_ok is issued after reset deasserts.
- Request contents may change while addr_ok=0; only the values in the grant cycle are used.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - starve_cnt is replaced by a 1-bit last_grant register (reset value = INST, so data wins the first conflict).
  - On conflict, the port not granted last wins.
  - last_grant updates on every grant.
  - STARVE_LIMIT is ignored.
- Not defined: data-priority plus starvation policy as above.

Test Plan:
- Reset:
  - Hold resetn=0 for 3 cycles with inst_req=data_req=1 -> addr_ok=0 and mem_en=0 throughout.
  - Release -> first cycle grants data (data_addr_ok=1, mem_addr=data_addr).
- Single fetch stream:
  - inst_req=1 with addr 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; memory returns 0x11, 0x22, 0x33.
  - Required: inst_addr_ok=1 each cycle; inst_data_ok=1 on the next 3 cycles with rdata 0x11, 0x22, 0x33.
- Store then load:
  - data_wr=1, addr 0x100, wstrb=4'b0011, wdata=0xAABBCCDD.
  - Required: mem_we=4'b0011; next cycle data_data_ok=1 with data_rdata=0.
  - Then a load of 0x100 with mem_rdata=0x0000CCDD -> data_rdata=0x0000CCDD.
- Starvation (default, STARVE_LIMIT=4):
  - inst_req and data_req held at 1 continuously.
  - Required: data granted cycles 0–3, inst granted cycle 4, data cycles 5–8, inst cycle 9; responses routed to the matching port.
- Round robin (ARB_ROUND_ROBIN_EN defined):
  - Both held at 1 -> grants alternate D, I, D, I from reset.
- Reset mid-flight:
  - Data load granted, resetn=0 on the next edge -> data_data_ok never asserts; after release the arbiter is idle with starve_cnt=0.
